// File: rtl/ram_1wrs_arbiter.sv
// Two-port arbiter in front of one single-port, write-through RAM with 1-cycle read latency.
// Each port gets a valid/ready command stream and a valid/ready response stream with stall hold.

module ram_1wrs_arbiter_rsp #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  accept_i,
  input  logic                  rsp_ready_i,
  input  logic [DATA_WIDTH-1:0] rd_data_i,
  output logic                  rsp_valid_o,
  output logic [DATA_WIDTH-1:0] rsp_data_o,
  output logic                  busy_o
);
  logic                  acc_q, held_q;
  logic [DATA_WIDTH-1:0] hold_q;

  // acc_q: the RAM output is live this cycle; held_q: a stalled response sits in hold_q.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q  <= 1'b0;
      held_q <= 1'b0;
    end else begin
      acc_q <= accept_i;
      if (acc_q && !rsp_ready_i)
        held_q <= 1'b1;
      else if (held_q && rsp_ready_i)
        held_q <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (acc_q && !rsp_ready_i)
      hold_q <= rd_data_i;
  end

  assign busy_o      = acc_q | held_q;
  assign rsp_valid_o = busy_o & ~reset;
  assign rsp_data_o  = held_q ? hold_q : rd_data_i;
endmodule

module ram_1wrs_arbiter #(
  parameter int ADDR_WIDTH     = 11,
  parameter int DATA_WIDTH     = 32,
  parameter bit FIXED_PRIORITY = 1'b0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  p0_cmd_valid,
  output logic                  p0_cmd_ready,
  input  logic                  p0_cmd_write,
  input  logic                  p0_cmd_mask,
  input  logic [ADDR_WIDTH-1:0] p0_cmd_addr,
  input  logic [DATA_WIDTH-1:0] p0_cmd_data,
  output logic                  p0_rsp_valid,
  input  logic                  p0_rsp_ready,
  output logic [DATA_WIDTH-1:0] p0_rsp_data,
  input  logic                  p1_cmd_valid,
  output logic                  p1_cmd_ready,
  input  logic                  p1_cmd_write,
  input  logic                  p1_cmd_mask,
  input  logic [ADDR_WIDTH-1:0] p1_cmd_addr,
  input  logic [DATA_WIDTH-1:0] p1_cmd_data,
  output logic                  p1_rsp_valid,
  input  logic                  p1_rsp_ready,
  output logic [DATA_WIDTH-1:0] p1_rsp_data,
  output logic                  ram_en,
  output logic                  ram_wr,
  output logic                  ram_mask,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_wrData,
  input  logic [DATA_WIDTH-1:0] ram_rdData
);
  localparam int NUM_PORTS = 2;

  logic [NUM_PORTS-1:0]                 cmd_valid, rsp_ready, rsp_valid, busy, elig, grant;
  logic [NUM_PORTS-1:0][DATA_WIDTH-1:0] rsp_data;
  logic                                 last_grant_q, last_grant_d;

  assign cmd_valid = {p1_cmd_valid, p0_cmd_valid};
  assign rsp_ready = {p1_rsp_ready, p0_rsp_ready};

  // A port may issue again only if its previous response leaves this cycle.
  assign elig = cmd_valid & (~busy | (rsp_valid & rsp_ready));

  always_comb begin
    grant = '0;
    if (!reset) begin
      grant[0] = elig[0] && (!elig[1] || FIXED_PRIORITY || last_grant_q);
      grant[1] = elig[1] && !grant[0];
    end
  end

  always_comb begin
    last_grant_d = last_grant_q;
    if (|grant)
      last_grant_d = grant[1];
  end

  always_ff @(posedge clk) begin
    if (reset)
      last_grant_q <= 1'b1;
    else
      last_grant_q <= last_grant_d;
  end

  assign ram_en     = |grant;
  assign ram_wr     = grant[1] ? p1_cmd_write : (grant[0] & p0_cmd_write);
  assign ram_mask   = grant[1] ? p1_cmd_mask  : (grant[0] & p0_cmd_mask);
  assign ram_addr   = grant[1] ? p1_cmd_addr  : p0_cmd_addr;
  assign ram_wrData = grant[1] ? p1_cmd_data  : p0_cmd_data;

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    ram_1wrs_arbiter_rsp #(.DATA_WIDTH(DATA_WIDTH)) u_rsp (
      .clk         (clk),
      .reset       (reset),
      .accept_i    (grant[p]),
      .rsp_ready_i (rsp_ready[p]),
      .rd_data_i   (ram_rdData),
      .rsp_valid_o (rsp_valid[p]),
      .rsp_data_o  (rsp_data[p]),
      .busy_o      (busy[p])
    );
  end

  assign p0_cmd_ready = grant[0];
  assign p1_cmd_ready = grant[1];
  assign p0_rsp_valid = rsp_valid[0];
  assign p1_rsp_valid = rsp_valid[1];
  assign p0_rsp_data  = rsp_data[0];
  assign p1_rsp_data  = rsp_data[1];
endmodule

// File: tb/tb_ram_1wrs_arbiter.sv
// Directed bench: round-robin DUT (a_*) and fixed-priority DUT (b_*) share command inputs,
// each backed by its own write-through RAM model.
module tb_ram_1wrs_arbiter;
  localparam int AW = 11;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          p0_cmd_valid, p0_cmd_write, p0_cmd_mask, p0_rsp_ready;
  logic          p1_cmd_valid, p1_cmd_write, p1_cmd_mask, p1_rsp_ready;
  logic [AW-1:0] p0_cmd_addr, p1_cmd_addr;
  logic [DW-1:0] p0_cmd_data, p1_cmd_data;

  logic          a_p0_cmd_ready, a_p1_cmd_ready, a_p0_rsp_valid, a_p1_rsp_valid;
  logic [DW-1:0] a_p0_rsp_data, a_p1_rsp_data, a_ram_wrData, a_ram_rdData;
  logic          a_ram_en, a_ram_wr, a_ram_mask;
  logic [AW-1:0] a_ram_addr;
  logic          b_p0_cmd_ready, b_p1_cmd_ready, b_p0_rsp_valid, b_p1_rsp_valid;
  logic [DW-1:0] b_p0_rsp_data, b_p1_rsp_data, b_ram_wrData, b_ram_rdData;
  logic          b_ram_en, b_ram_wr, b_ram_mask;
  logic [AW-1:0] b_ram_addr;

  logic [DW-1:0] mem_a [0:(1<<AW)-1];
  logic [DW-1:0] mem_b [0:(1<<AW)-1];

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  ram_1wrs_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FIXED_PRIORITY(1'b0)) u_a (
    .clk(clk), .reset(reset),
    .p0_cmd_valid(p0_cmd_valid), .p0_cmd_ready(a_p0_cmd_ready), .p0_cmd_write(p0_cmd_write),
    .p0_cmd_mask(p0_cmd_mask), .p0_cmd_addr(p0_cmd_addr), .p0_cmd_data(p0_cmd_data),
    .p0_rsp_valid(a_p0_rsp_valid), .p0_rsp_ready(p0_rsp_ready), .p0_rsp_data(a_p0_rsp_data),
    .p1_cmd_valid(p1_cmd_valid), .p1_cmd_ready(a_p1_cmd_ready), .p1_cmd_write(p1_cmd_write),
    .p1_cmd_mask(p1_cmd_mask), .p1_cmd_addr(p1_cmd_addr), .p1_cmd_data(p1_cmd_data),
    .p1_rsp_valid(a_p1_rsp_valid), .p1_rsp_ready(p1_rsp_ready), .p1_rsp_data(a_p1_rsp_data),
    .ram_en(a_ram_en), .ram_wr(a_ram_wr), .ram_mask(a_ram_mask), .ram_addr(a_ram_addr),
    .ram_wrData(a_ram_wrData), .ram_rdData(a_ram_rdData)
  );

  ram_1wrs_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FIXED_PRIORITY(1'b1)) u_b (
    .clk(clk), .reset(reset),
    .p0_cmd_valid(p0_cmd_valid), .p0_cmd_ready(b_p0_cmd_ready), .p0_cmd_write(p0_cmd_write),
    .p0_cmd_mask(p0_cmd_mask), .p0_cmd_addr(p0_cmd_addr), .p0_cmd_data(p0_cmd_data),
    .p0_rsp_valid(b_p0_rsp_valid), .p0_rsp_ready(p0_rsp_ready), .p0_rsp_data(b_p0_rsp_data),
    .p1_cmd_valid(p1_cmd_valid), .p1_cmd_ready(b_p1_cmd_ready), .p1_cmd_write(p1_cmd_write),
    .p1_cmd_mask(p1_cmd_mask), .p1_cmd_addr(p1_cmd_addr), .p1_cmd_data(p1_cmd_data),
    .p1_rsp_valid(b_p1_rsp_valid), .p1_rsp_ready(p1_rsp_ready), .p1_rsp_data(b_p1_rsp_data),
    .ram_en(b_ram_en), .ram_wr(b_ram_wr), .ram_mask(b_ram_mask), .ram_addr(b_ram_addr),
    .ram_wrData(b_ram_wrData), .ram_rdData(b_ram_rdData)
  );

  // Write-through RAM models: a write access returns its write data whatever the mask.
  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < (1<<AW); i++) mem_a[i] <= '0;
      a_ram_rdData <= '0;
    end else if (a_ram_en) begin
      if (a_ram_wr && a_ram_mask) mem_a[a_ram_addr] <= a_ram_wrData;
      a_ram_rdData <= a_ram_wr ? a_ram_wrData : mem_a[a_ram_addr];
    end
  end

  always @(posedge clk) begin
    if (reset) begin
      for (int j = 0; j < (1<<AW); j++) mem_b[j] <= '0;
      b_ram_rdData <= '0;
    end else if (b_ram_en) begin
      if (b_ram_wr && b_ram_mask) mem_b[b_ram_addr] <= b_ram_wrData;
      b_ram_rdData <= b_ram_wr ? b_ram_wrData : mem_b[b_ram_addr];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Inputs change just after a rising edge; outputs are checked #1 later, well before the next edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    p0_cmd_valid = 1'b0; p0_cmd_write = 1'b0; p0_cmd_mask = 1'b0;
    p1_cmd_valid = 1'b0; p1_cmd_write = 1'b0; p1_cmd_mask = 1'b0;
  endtask

  task automatic cmd0(input logic wr, input logic msk, input logic [AW-1:0] ad, input logic [DW-1:0] d);
    p0_cmd_valid = 1'b1; p0_cmd_write = wr; p0_cmd_mask = msk; p0_cmd_addr = ad; p0_cmd_data = d;
  endtask

  task automatic cmd1(input logic wr, input logic msk, input logic [AW-1:0] ad, input logic [DW-1:0] d);
    p1_cmd_valid = 1'b1; p1_cmd_write = wr; p1_cmd_mask = msk; p1_cmd_addr = ad; p1_cmd_data = d;
  endtask

  initial begin
    logic exp0;
    reset = 1'b1;
    idle();
    p0_cmd_addr = '0; p0_cmd_data = '0; p1_cmd_addr = '0; p1_cmd_data = '0;
    p0_rsp_ready = 1'b1; p1_rsp_ready = 1'b1;
    tick(); tick();

    // Commands during reset are refused
    cmd0(1'b0, 1'b0, 11'd5, 32'h0); #1;
    chk("rst_cmd_ready", {31'd0, a_p0_cmd_ready}, 32'd0);
    chk("rst_ram_en", {31'd0, a_ram_en}, 32'd0);
    tick();
    reset = 1'b0; idle(); #1;
    chk("post_rst_rsp_valid", {30'd0, a_p1_rsp_valid, a_p0_rsp_valid}, 32'd0);
    tick();

    // 1: read @5 of preloaded zero, 1-cycle latency
    cmd0(1'b0, 1'b0, 11'd5, 32'h0); #1;
    chk("t1_ready", {31'd0, a_p0_cmd_ready}, 32'd1);
    chk("t1_ram_addr", {21'd0, a_ram_addr}, 32'd5);
    tick();
    idle(); #1;
    chk("t1_rsp_valid", {31'd0, a_p0_rsp_valid}, 32'd1);
    chk("t1_rsp_data", a_p0_rsp_data, 32'h0);
    tick(); #1;
    chk("t1_rsp_gone", {31'd0, a_p0_rsp_valid}, 32'd0);

    // 2: write then back-to-back read of the same word
    cmd0(1'b1, 1'b1, 11'd3, 32'hDEADBEEF); #1;
    chk("t2_wr_ready", {30'd0, a_ram_wr, a_p0_cmd_ready}, 32'd3);
    tick();
    cmd0(1'b0, 1'b0, 11'd3, 32'h0); #1;
    chk("t2_wr_rsp", a_p0_rsp_data, 32'hDEADBEEF);
    chk("t2_b2b_ready", {30'd0, a_p0_rsp_valid, a_p0_cmd_ready}, 32'd3);
    tick();
    idle(); #1;
    chk("t2_rd_rsp", a_p0_rsp_data, 32'hDEADBEEF);
    tick();

    // 3: contention; last winner was p0, so round-robin starts with p1
    exp0 = 1'b0;
    for (int c = 0; c < 6; c++) begin
      cmd0(1'b0, 1'b0, 11'd0, 32'h0);
      cmd1(1'b0, 1'b0, 11'd1, 32'h0); #1;
      chk("t3_rr_grant", {30'd0, a_p1_cmd_ready, a_p0_cmd_ready}, {30'd0, ~exp0, exp0});
      chk("t3_fp_grant", {30'd0, b_p1_cmd_ready, b_p0_cmd_ready}, 32'd1);
      exp0 = ~exp0;
      tick();
    end
    idle(); tick();

    // 4: p1 response stall holds data and blocks p1 while p0 proceeds
    cmd1(1'b1, 1'b1, 11'd9, 32'h12345678); #1;
    chk("t4_wr_ready", {31'd0, a_p1_cmd_ready}, 32'd1);
    tick();
    cmd1(1'b0, 1'b0, 11'd9, 32'h0); #1;
    chk("t4_rd_ready", {31'd0, a_p1_cmd_ready}, 32'd1);
    tick();
    p1_rsp_ready = 1'b0;
    for (int s = 0; s < 4; s++) begin
      cmd0(1'b0, 1'b0, 11'd5, 32'h0); #1;
      chk("t4_stall_valid", {31'd0, a_p1_rsp_valid}, 32'd1);
      chk("t4_stall_data", a_p1_rsp_data, 32'h12345678);
      chk("t4_stall_grant", {30'd0, a_p1_cmd_ready, a_p0_cmd_ready}, 32'd1);
      tick();
    end
    p1_rsp_ready = 1'b1; #1;
    chk("t4_hs_data", a_p1_rsp_data, 32'h12345678);
    chk("t4_hs_grant", {30'd0, a_p1_cmd_ready, a_p0_cmd_ready}, 32'd2);
    tick();
    idle(); #1;
    chk("t4_new_rsp", {a_p1_rsp_data[30:0], a_p1_rsp_valid}, {31'h12345678 & 31'h7FFFFFFF, 1'b1});
    chk("t4_p0_idle", {31'd0, a_p0_rsp_valid}, 32'd0);
    tick();

    // 5: masked-off write echoes its data but leaves the word unchanged
    cmd0(1'b1, 1'b0, 11'd3, 32'hAAAA5555); #1;
    chk("t5_mask", {30'd0, a_ram_mask, a_p0_cmd_ready}, 32'd1);
    tick();
    cmd0(1'b0, 1'b0, 11'd3, 32'h0); #1;
    chk("t5_wr_rsp", a_p0_rsp_data, 32'hAAAA5555);
    tick();
    idle(); #1;
    chk("t5_rd_rsp", a_p0_rsp_data, 32'hDEADBEEF);
    tick();

    // 6: reset right after an accept drops the response; p0 wins first contention afterwards
    cmd1(1'b0, 1'b0, 11'd5, 32'h0); #1;
    chk("t6_acc", {31'd0, a_p1_cmd_ready}, 32'd1);
    tick();
    reset = 1'b1; idle(); #1;
    chk("t6_rst_rsp", {30'd0, a_p1_rsp_valid, a_p0_rsp_valid}, 32'd0);
    tick();
    reset = 1'b0; #1;
    chk("t6_after_rsp", {30'd0, a_p1_rsp_valid, a_p0_rsp_valid}, 32'd0);
    cmd0(1'b0, 1'b0, 11'd1, 32'h0);
    cmd1(1'b0, 1'b0, 11'd2, 32'h0); #1;
    chk("t6_first_grant", {30'd0, a_p1_cmd_ready, a_p0_cmd_ready}, 32'd1);
    tick();
    idle(); tick();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end
endmodule
